// File: rtl/fifo_apb_drain_if.sv
// APB requester-side bus bundle for fifo_apb_drain.
// The master modport is the drain engine, the slave modport is the APB completer.
interface fifo_apb_drain_if #(
    parameter int ADDR_W = 32
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, pslverr
    );
endinterface

// File: rtl/fifo_apb_drain.sv
// fifo_apb_drain: pops len_i words from an 8-deep FIFO and writes each one
// over APB to base_addr_i, base_addr_i+ADDR_STEP, ... (wrapping).
// Optional feature macro: APB_DRAIN_ABORT_ON_ERR_EN -- when defined, a slave
// error ends the burst at once and leaves the remaining words in the FIFO.
// Note: rst_n is asynchronous and active-HIGH despite its name.
module fifo_apb_drain #(
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // control agent
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [7:0]        len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    // FIFO read side
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic [31:0]       fifo_data_i,
    // APB requester
    fifo_apb_drain_if.master  apb
);

`ifdef APB_DRAIN_ABORT_ON_ERR_EN
    localparam bit ABORT_ON_ERR = 1'b1;
`else
    localparam bit ABORT_ON_ERR = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        remaining_q;
    logic [31:0]       pwdata_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    // The pop strobe must follow the empty flag in the same cycle, so it is
    // the one output that is decoded from state rather than registered.
    assign fifo_rd_en_o = (state_q == POP) && !fifo_empty_i;

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = addr_q;
    assign apb.pwdata  = pwdata_q;

    // Burst FSM with registered outputs; outputs are set for the state being entered.
    // NOTE: every register here uses <= so all of them sample pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len_i != 8'd0) begin
                            addr_q      <= base_addr_i;
                            remaining_q <= len_i;
                            state_q     <= POP;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                POP: begin
                    if (!fifo_empty_i) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // FIFO read data is valid the cycle after the pop.
                    pwdata_q <= fifo_data_i;
                    psel_q   <= 1'b1;
                    pwrite_q <= 1'b1;
                    state_q  <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready) begin
                        err_q       <= err_q | apb.pslverr;
                        addr_q      <= addr_q + ADDR_W'(ADDR_STEP);
                        remaining_q <= remaining_q - 8'd1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        if ((remaining_q == 8'd1) || (ABORT_ON_ERR && apb.pslverr)) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= POP;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    pwrite_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_apb_drain.sv
// Self-checking bench for fifo_apb_drain: a queue-based FIFO model, an APB
// completer with per-word wait/error tables, table-driven bursts, a reset
// sequence and randomized bursts checked against a transaction-level model.
module tb_fifo_apb_drain;

`ifdef APB_DRAIN_ABORT_ON_ERR_EN
    localparam bit ABORT_MODE = 1'b1;
`else
    localparam bit ABORT_MODE = 1'b0;
`endif
    localparam int STEP = 4;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [7:0]  len_i;
    logic        busy_o, done_o, err_o;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_data;

    fifo_apb_drain_if #(.ADDR_W(32)) apb_bus ();

    fifo_apb_drain #(.ADDR_W(32), .ADDR_STEP(STEP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_data_i  (fifo_data),
        .apb          (apb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [31:0] fifo_q[$];
    int          pop_cnt;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data  <= fifo_q[0];
            fifo_q.pop_front();
            fifo_empty <= (fifo_q.size() == 0);
            pop_cnt++;
        end
    end

    task automatic fifo_push(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic fifo_flush();
        fifo_q.delete();
        fifo_empty = 1'b1;
    endtask

    // ---------------- APB completer model ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       xfers[$];
    int          wait_tab[16];
    bit          err_tab[16];
    int          xfer_idx;
    int          acc_cnt;
    int          psel_cnt;
    int          stab_err;
    logic [31:0] s_addr, s_data;

    always @(negedge clk) begin
        if (apb_bus.pwrite !== apb_bus.psel) stab_err++;
        if (apb_bus.penable && !apb_bus.psel) stab_err++;
        if (apb_bus.psel && !apb_bus.penable) begin
            s_addr = apb_bus.paddr;
            s_data = apb_bus.pwdata;
        end
        if (apb_bus.psel && apb_bus.penable) begin
            if (apb_bus.paddr !== s_addr || apb_bus.pwdata !== s_data) stab_err++;
            apb_bus.pready  = (acc_cnt >= wait_tab[xfer_idx % 16]);
            apb_bus.pslverr = apb_bus.pready && err_tab[xfer_idx % 16];
        end else begin
            apb_bus.pready  = 1'b0;
            apb_bus.pslverr = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (apb_bus.psel) psel_cnt++;
        if (apb_bus.psel && apb_bus.penable) begin
            if (apb_bus.pready) begin
                xfers.push_back('{addr: apb_bus.paddr, data: apb_bus.pwdata});
                xfer_idx++;
                acc_cnt = 0;
            end else begin
                acc_cnt++;
            end
        end
    end

    // ---------------- burst runner + reference model ----------------
    // push_at = 0: all words preloaded; push_at = p > 0: all words pushed in cycle p.
    // exp_done_tab / exp_left_tab < 0: no hand-derived table values for this burst.
    task automatic run_burst(input string name, input logic [31:0] base, input int len,
                             input int push_at, input bit spurious,
                             input int exp_done_tab, input int exp_left_tab);
        logic [31:0] words[8];
        int          n_wr, exp_done, exp_psel, got_done;
        bit          exp_err, early_pop;
        logic [31:0] exp_addr;

        // transaction-level expectation
        n_wr    = 0;
        exp_err = 1'b0;
        for (int k = 0; k < len; k++) begin
            n_wr++;
            if (err_tab[k]) begin
                exp_err = 1'b1;
                if (ABORT_MODE) break;
            end
        end
        exp_done = 1;
        exp_psel = 0;
        if (len > 0 && push_at > 0) exp_done += push_at - 1;
        for (int k = 0; k < n_wr; k++) begin
            exp_done += 4 + wait_tab[k];
            exp_psel += 2 + wait_tab[k];
        end

        // stimulus
        fifo_flush();
        for (int k = 0; k < 8; k++) words[k] = $urandom;
        if (push_at == 0)
            for (int k = 0; k < len; k++) fifo_push(words[k]);
        xfers.delete();
        pop_cnt   = 0;
        psel_cnt  = 0;
        stab_err  = 0;
        xfer_idx  = 0;
        acc_cnt   = 0;
        early_pop = 1'b0;
        got_done  = -1;

        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = base;
        len_i       = 8'(len);
        @(posedge clk);
        for (int c = 1; c < 2000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_i = 1'b0;
                check({name, " busy after start"}, 64'(busy_o), 64'd1);
            end
            if (spurious && c == 2) begin
                start_i     = 1'b1;
                base_addr_i = 32'hDEAD_0000;
                len_i       = 8'd5;
            end
            if (spurious && c == 3) start_i = 1'b0;
            if (push_at > 0 && len > 0 && c <= push_at) begin
                if (fifo_rd_en) early_pop = 1'b1;
                if (c == push_at)
                    for (int k = 0; k < len; k++) fifo_push(words[k]);
            end
            if (done_o) begin
                got_done = c;
                break;
            end
        end

        check({name, " done cycle"}, 64'(got_done), 64'(exp_done));
        if (exp_done_tab >= 0)
            check({name, " done cycle (table)"}, 64'(got_done), 64'(exp_done_tab));
        check({name, " err_o"}, 64'(err_o), 64'(exp_err));
        @(negedge clk);
        check({name, " done one cycle"}, 64'(done_o), 64'd0);
        check({name, " busy cleared"}, 64'(busy_o), 64'd0);
        check({name, " write count"}, 64'(xfers.size()), 64'(n_wr));
        for (int k = 0; k < n_wr && k < xfers.size(); k++) begin
            exp_addr = base + 32'(k * STEP);
            check($sformatf("%s addr[%0d]", name, k), 64'(xfers[k].addr), 64'(exp_addr));
            check($sformatf("%s data[%0d]", name, k), 64'(xfers[k].data), 64'(words[k]));
        end
        check({name, " pops"}, 64'(pop_cnt), 64'(n_wr));
        check({name, " fifo left"}, 64'(fifo_q.size()), 64'(len - n_wr));
        if (exp_left_tab >= 0)
            check({name, " fifo left (table)"}, 64'(fifo_q.size()), 64'(exp_left_tab));
        check({name, " psel cycles"}, 64'(psel_cnt), 64'(exp_psel));
        check({name, " bus stability"}, 64'(stab_err), 64'd0);
        if (push_at > 0 && len > 0)
            check({name, " no pop while empty"}, 64'(early_pop), 64'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] base;
        int          len;
        int          push_at;
        int          wait_w;
        int          wait_n;
        int          err_w;
        bit          spurious;
        int          exp_done;
        int          exp_left;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit          seen;
        bit          done_seen;
        logic [31:0] rbase;
        int          rlen, rpush;

        rst_n       = 1'b1;
        start_i     = 1'b0;
        base_addr_i = '0;
        len_i       = '0;
        fifo_empty  = 1'b1;
        fifo_data   = '0;
        pop_cnt     = 0;
        xfer_idx    = 0;
        acc_cnt     = 0;
        psel_cnt    = 0;
        stab_err    = 0;
        s_addr      = '0;
        s_data      = '0;
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        for (int k = 0; k < 16; k++) begin
            wait_tab[k] = 0;
            err_tab[k]  = 1'b0;
        end

        //            base          len push wait_w wait_n err_w spur done                  left
        vecs[0] = '{32'h0000_0100, 3, 0, -1, 0, -1, 1'b0, 13,                      0};
        vecs[1] = '{32'h0000_0200, 3, 0,  1, 2, -1, 1'b1, 15,                      0};
        vecs[2] = '{32'h0000_0300, 1, 5, -1, 0, -1, 1'b0, 9,                       0};
        vecs[3] = '{32'h0000_0000, 0, 0, -1, 0, -1, 1'b0, 1,                       0};
        vecs[4] = '{32'hFFFF_FFFC, 2, 0, -1, 0, -1, 1'b0, 9,                       0};
        vecs[5] = '{32'h0000_0400, 4, 0, -1, 0,  0, 1'b0, ABORT_MODE ? 5 : 17,     ABORT_MODE ? 3 : 0};
        vecs[6] = '{32'h0000_0600, 2, 0, -1, 0, -1, 1'b0, 9,                       0};

        // reset state
        repeat (2) @(negedge clk);
        check("reset psel",    64'(apb_bus.psel),    64'd0);
        check("reset penable", 64'(apb_bus.penable), 64'd0);
        check("reset pwrite",  64'(apb_bus.pwrite),  64'd0);
        check("reset paddr",   64'(apb_bus.paddr),   64'd0);
        check("reset pwdata",  64'(apb_bus.pwdata),  64'd0);
        check("reset busy/done/err/rd_en", {60'd0, busy_o, done_o, err_o, fifo_rd_en}, 64'd0);
        rst_n = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 16; k++) begin
                wait_tab[k] = (k == vecs[i].wait_w) ? vecs[i].wait_n : 0;
                err_tab[k]  = (k == vecs[i].err_w);
            end
            if (i == 6) check("err_o sticky after error burst", 64'(err_o), 64'd1);
            run_burst($sformatf("vec%0d", i), vecs[i].base, vecs[i].len, vecs[i].push_at,
                      vecs[i].spurious, vecs[i].exp_done, vecs[i].exp_left);
        end

        // reset while the completer stalls in ACCESS
        for (int k = 0; k < 16; k++) begin
            wait_tab[k] = 0;
            err_tab[k]  = 1'b0;
        end
        wait_tab[0] = 50;
        fifo_flush();
        fifo_push(32'h1111_1111);
        fifo_push(32'h2222_2222);
        xfer_idx = 0;
        acc_cnt  = 0;
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = 32'h0000_0500;
        len_i       = 8'd2;
        @(negedge clk);
        start_i = 1'b0;
        seen    = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (apb_bus.psel && apb_bus.penable) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstseq reached ACCESS", 64'(seen), 64'd1);
        #2 rst_n = 1'b1;
        #1;
        check("rstseq psel async drop",    64'(apb_bus.psel),    64'd0);
        check("rstseq penable async drop", 64'(apb_bus.penable), 64'd0);
        check("rstseq busy async drop",    64'(busy_o),          64'd0);
        @(negedge clk);
        rst_n     = 1'b0;
        acc_cnt   = 0;
        done_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done_o || apb_bus.psel) done_seen = 1'b1;
        end
        check("rstseq no done after reset", 64'(done_seen), 64'd0);
        wait_tab[0] = 0;

        // randomized bursts against the transaction-level model
        for (int r = 0; r < 30; r++) begin
            rlen  = $urandom_range(0, 8);
            rbase = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                                : ($urandom & 32'hFFFF_FFFC);
            rpush = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            for (int k = 0; k < 16; k++) begin
                wait_tab[k] = $urandom_range(0, 2);
                err_tab[k]  = ($urandom_range(0, 5) == 0);
            end
            run_burst($sformatf("rand%0d", r), rbase, rlen, rpush, 1'b0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
